ram_2port_rw_ctrl: RTL and testbench
====================================

RAM_2PORT_RW_CTRL -- requirements
Module: ram_2port_rw_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 5, RAM address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 SHALL provide parameter RD_LATENCY, default 1, legal values 1 or 2: number of cycles from rd_addr presented to rd_data valid (1 = no RAM output reg, 2 = output reg).
REQ-004 SHALL provide parameter DATA_INIT, default 8'hFF (DATA_WIDTH bits), the first write data value.
REQ-005 sys_clk  in  1  single clock for all logic; also drives the RAM wr_clk and rd_clk.
REQ-006 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request one write-then-read-check pass; sampled only in IDLE.
REQ-008 wr_en  out  1  RAM write enable.
REQ-009 wr_addr  out  ADDR_WIDTH  RAM write address.
REQ-010 wr_data  out  DATA_WIDTH  RAM write data.
REQ-011 rd_addr  out  ADDR_WIDTH  RAM read address.
REQ-012 rd_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after rd_addr.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at the end of a pass.
REQ-015 err  out  1  sticky mismatch flag for the current or last pass.
REQ-016 err_cnt  out  8  mismatch count, saturates at 255.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states SHALL be IDLE, WRITE, READ, FLUSH, DONE.
REQ-019 IDLE & start -> WRITE; start in any other state SHALL be ignored.
REQ-020 On accepting start, err and err_cnt SHALL clear to 0 and the write/read index SHALL clear to 0.
REQ-021 WRITE: wr_en=1 for exactly 2**ADDR_WIDTH consecutive cycles; wr_addr = index 0..2**ADDR_WIDTH-1; wr_data = DATA_INIT - index, modulo 2**DATA_WIDTH (default: addr 0 -> 8'hFF, addr 31 -> 8'hE0).
REQ-022 The first write (addr 0) SHALL appear in the cycle after start is sampled.
REQ-023 WRITE with index at last address -> READ next cycle; index wraps to 0 with no extra idle cycle.
REQ-024 READ: rd_addr = index 0..2**ADDR_WIDTH-1 for exactly 2**ADDR_WIDTH consecutive cycles; wr_en=0.
REQ-025 READ at last address -> FLUSH; FLUSH SHALL last exactly RD_LATENCY cycles, then DONE.
REQ-026 A RD_LATENCY-deep valid/expected pipeline SHALL carry, for each read issued in cycle N, the expected value DATA_INIT - addr; rd_data SHALL be compared at the sys_clk edge ending cycle N+RD_LATENCY.
REQ-027 On a compared mismatch, err SHALL set and err_cnt SHALL increment by 1, holding at 255 once reached.
REQ-028 DONE SHALL last exactly one cycle with done=1, then IDLE; err and err_cnt SHALL hold their values until the next accepted start.
REQ-029 Outside WRITE, wr_en=0, wr_addr=0 and wr_data=0; outside READ, rd_addr=0.
REQ-030 A pass SHALL take 2*2**ADDR_WIDTH + RD_LATENCY + 1 cycles from the first write to done (default: 66 for RD_LATENCY=1).
REQ-031 start held high continuously SHALL start a new pass one cycle after each DONE.

Reset
REQ-032 sys_rst_n low SHALL immediately force state IDLE, index 0, the compare pipeline empty, and all outputs 0 (wr_en, wr_addr, wr_data, rd_addr, busy, done, err, err_cnt).
REQ-033 A reset asserted mid-pass SHALL abort the pass with no done pulse, and no compares SHALL be made from the in-flight pipeline.
REQ-034 After reset release, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-035 Nominal (defaults, ideal RAM model): 1-cycle start pulse -> 32 writes with FF..E0 at addr 0..31, then 32 reads, done at cycle 66 after the first write, err=0, err_cnt=0.
REQ-036 Fault injection: RAM model corrupts addr 7 and addr 20 -> err=1, err_cnt=2 after done; a new start clears both to 0.
REQ-037 All-mismatch (rd_data stuck at 0) with ADDR_WIDTH=9 -> err_cnt saturates at 255 and does not wrap.
REQ-038 RD_LATENCY=2 with an output-registered RAM model -> err=0; FLUSH lasts 2 cycles; done at cycle 67.
REQ-039 sys_rst_n pulsed low during READ at addr 10 -> all outputs 0 at once, no done pulse; the next start runs a clean pass with err=0.
REQ-040 start toggled during WRITE/READ -> ignored, so there is exactly one pass; start held high -> back-to-back passes, each separated by a single IDLE cycle.

Source files
------------

// File: rtl/ram_2port_rw_ctrl_if.sv
// Bus between the RAM write/read-check controller and the dual-port RAM plus its
// control/status signals. The controller side uses the master modport.
interface ram_2port_rw_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) ();
    logic                  start;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [7:0]            err_cnt;

    modport master (
        input  start, rd_data,
        output wr_en, wr_addr, wr_data, rd_addr, busy, done, err, err_cnt
    );

    modport slave (
        output start, rd_data,
        input  wr_en, wr_addr, wr_data, rd_addr, busy, done, err, err_cnt
    );
endinterface

// File: rtl/ram_2port_rw_ctrl.sv
// Write-then-read-check controller: fills the RAM with DATA_INIT - addr, reads it
// back and counts mismatches through a RD_LATENCY-deep expected-value pipeline.
module ram_2port_rw_ctrl #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] DATA_INIT  = '1
) (
    input logic sys_clk,
    input logic sys_rst_n,
    ram_2port_rw_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = '1;
    localparam logic [ADDR_WIDTH-1:0] FLUSH_LAST = ADDR_WIDTH'(RD_LATENCY - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx, idx_nxt;
    logic                  accept;
    logic                  mismatch;

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_exp [RD_LATENCY];

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [7:0]            err_cnt_q;

    // idx doubles as the FLUSH cycle counter; it wraps from LAST_IDX to 0 into READ.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = WRITE;
                    idx_nxt   = '0;
                    accept    = 1'b1;
                end
            end
            WRITE: begin
                idx_nxt = idx + 1'b1;
                if (idx == LAST_IDX) state_nxt = READ;
            end
            READ: begin
                if (idx == LAST_IDX) begin
                    state_nxt = FLUSH;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            FLUSH: begin
                if (idx == FLUSH_LAST) begin
                    state_nxt = DONE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mismatch = pipe_vld[RD_LATENCY-1] && (bus.rd_data != pipe_exp[RD_LATENCY-1]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_exp[i] <= '0;
        end else begin
            pipe_vld[0] <= (state == READ);
            pipe_exp[0] <= DATA_INIT - DATA_WIDTH'(idx);
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
            end
        end
    end

    // Outputs are registered from the next state so they line up with state/idx.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_en_q   <= (state_nxt == WRITE);
            wr_addr_q <= (state_nxt == WRITE) ? idx_nxt : '0;
            wr_data_q <= (state_nxt == WRITE) ? DATA_INIT - DATA_WIDTH'(idx_nxt) : '0;
            rd_addr_q <= (state_nxt == READ) ? idx_nxt : '0;
            busy_q    <= (state_nxt != IDLE);
            done_q    <= (state_nxt == DONE);
            if (accept) begin
                err_q     <= 1'b0;
                err_cnt_q <= '0;
            end else if (mismatch) begin
                err_q <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_ram_2port_rw_ctrl.sv
// Scoreboard bench: three controller instances (default, RD_LATENCY=2, ADDR_WIDTH=9
// with rd_data stuck at 0) each paired with a behavioural RAM model.
module tb_ram_2port_rw_ctrl;
    typedef struct packed {
        logic        err;
        logic [7:0]  cnt;
        logic [15:0] len;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fault_en = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_2port_rw_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) if0 ();
    ram_2port_rw_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) if1 ();
    ram_2port_rw_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) if2 ();

    ram_2port_rw_ctrl u0 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if0));
    ram_2port_rw_ctrl #(.RD_LATENCY(2)) u1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if1));
    ram_2port_rw_ctrl #(.ADDR_WIDTH(9)) u2 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if2));

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    logic [7:0] rq1;

    // u0 RAM: one-cycle read, optional corruption of addresses 7 and 20
    always @(posedge clk) begin
        if (if0.wr_en) mem0[if0.wr_addr] <= if0.wr_data;
        if (fault_en && (if0.rd_addr == 5'd7 || if0.rd_addr == 5'd20))
            if0.rd_data <= ~mem0[if0.rd_addr];
        else
            if0.rd_data <= mem0[if0.rd_addr];
    end

    // u1 RAM: output-registered, two-cycle read
    always @(posedge clk) begin
        if (if1.wr_en) mem1[if1.wr_addr] <= if1.wr_data;
        rq1         <= mem1[if1.rd_addr];
        if1.rd_data <= rq1;
    end

    assign if2.rd_data = 8'h00;

    logic [12:0] wq0 [$];
    int          fwq0 [$];
    res_t        dq0 [$];
    res_t        dq1 [$];
    res_t        dq2 [$];
    int          fw0 = 0, fw1 = 0, fw2 = 0;
    int          done_cyc0 = 0;
    int          done_n0 = 0, done_n1 = 0, done_n2 = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents a write or a done pulse.
    always @(negedge clk) begin
        logic [12:0] w;
        int          efw;
        res_t        r;
        if (rst_n) begin
            if (if0.wr_en) begin
                if (if0.wr_addr == 5'd0) begin
                    chk("u0_pass_expected", fwq0.size() > 0, 1);
                    if (fwq0.size() > 0) begin
                        efw = fwq0.pop_front();
                        if (efw == 0) chk("u0_restart_gap", cyc - done_cyc0, 2);
                        else          chk("u0_first_write_cycle", cyc, efw);
                    end
                    fw0 = cyc;
                end
                chk("u0_write_expected", wq0.size() > 0, 1);
                if (wq0.size() > 0) begin
                    w = wq0.pop_front();
                    chk("u0_write", {if0.wr_addr, if0.wr_data}, w);
                end
            end else begin
                chk("u0_wr_outside_write", {if0.wr_addr, if0.wr_data}, 0);
            end
            if (!if0.busy) chk("u0_idle_outputs", {if0.rd_addr, if0.done}, 0);
            if (if0.done) begin
                chk("u0_done_expected", dq0.size() > 0, 1);
                if (dq0.size() > 0) begin
                    r = dq0.pop_front();
                    chk("u0_err", if0.err, r.err);
                    chk("u0_err_cnt", if0.err_cnt, r.cnt);
                    chk("u0_pass_len", cyc - fw0 + 1, r.len);
                end
                done_cyc0 = cyc;
                done_n0++;
            end

            if (if1.wr_en && if1.wr_addr == 5'd0) fw1 = cyc;
            if (if1.done) begin
                chk("u1_done_expected", dq1.size() > 0, 1);
                if (dq1.size() > 0) begin
                    r = dq1.pop_front();
                    chk("u1_err", if1.err, r.err);
                    chk("u1_err_cnt", if1.err_cnt, r.cnt);
                    chk("u1_pass_len", cyc - fw1 + 1, r.len);
                end
                done_n1++;
            end

            if (if2.wr_en && if2.wr_addr == 9'd0) fw2 = cyc;
            if (if2.done) begin
                chk("u2_done_expected", dq2.size() > 0, 1);
                if (dq2.size() > 0) begin
                    r = dq2.pop_front();
                    chk("u2_err", if2.err, r.err);
                    chk("u2_err_cnt", if2.err_cnt, r.cnt);
                    chk("u2_pass_len", cyc - fw2 + 1, r.len);
                end
                done_n2++;
            end
        end
    end

    task automatic push_writes0();
        for (int i = 0; i < 32; i++) begin
            logic [7:0] d;
            d = 8'hFF - 8'(i);
            wq0.push_back({5'(i), d});
        end
    endtask

    // Called at a negedge: raise start for one cycle and queue the pass's writes.
    task automatic start_pulse0();
        if0.start = 1'b1;
        fwq0.push_back(cyc + 1);
        push_writes0();
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic wait_cnt(input string name, input int which, input int target, input int budget);
        int i;
        int n;
        i = 0;
        n = (which == 0) ? done_n0 : (which == 1) ? done_n1 : done_n2;
        while (n < target && i < budget) begin
            @(negedge clk);
            i++;
            n = (which == 0) ? done_n0 : (which == 1) ? done_n1 : done_n2;
        end
        chk(name, n >= target, 1);
    endtask

    initial begin
        int base;
        int i;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("u0_reset_outputs", {if0.wr_en, if0.wr_addr, if0.wr_data, if0.rd_addr,
                                 if0.busy, if0.done, if0.err, if0.err_cnt}, 0);
        chk("u1_reset_outputs", {if1.wr_en, if1.busy, if1.done, if1.err, if1.err_cnt}, 0);
        chk("u2_reset_outputs", {if2.wr_en, if2.wr_addr, if2.rd_addr, if2.busy, if2.err_cnt}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("u0_stays_idle", if0.busy, 0);

        // Nominal pass on all three; u0 gets stray start pulses mid-pass
        dq0.push_back('{err: 1'b0, cnt: 8'd0, len: 16'd66});
        dq1.push_back('{err: 1'b0, cnt: 8'd0, len: 16'd67});
        dq2.push_back('{err: 1'b1, cnt: 8'd255, len: 16'd1026});
        if1.start = 1'b1;
        if2.start = 1'b1;
        start_pulse0();
        if1.start = 1'b0;
        if2.start = 1'b0;
        repeat (10) @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (30) @(negedge clk);
        if0.start = 1'b1;
        repeat (3) @(negedge clk);
        if0.start = 1'b0;
        wait_cnt("u0_done_timeout", 0, 1, 200);
        wait_cnt("u1_done_timeout", 1, 1, 200);
        wait_cnt("u2_done_timeout", 2, 1, 1200);
        repeat (3) @(negedge clk);
        chk("u2_cnt_held", if2.err_cnt, 255);

        // Fault injection at addresses 7 and 20
        fault_en = 1'b1;
        dq0.push_back('{err: 1'b1, cnt: 8'd2, len: 16'd66});
        start_pulse0();
        wait_cnt("u0_fault_timeout", 0, 2, 200);
        repeat (4) @(negedge clk);
        chk("u0_err_held", {if0.err, if0.err_cnt}, {1'b1, 8'd2});
        fault_en = 1'b0;
        dq0.push_back('{err: 1'b0, cnt: 8'd0, len: 16'd66});
        start_pulse0();
        chk("u0_err_cleared", {if0.err, if0.err_cnt}, 0);
        wait_cnt("u0_clean_timeout", 0, 3, 200);
        repeat (2) @(negedge clk);

        // start held high: two back-to-back passes one IDLE cycle apart
        base = done_n0;
        if0.start = 1'b1;
        fwq0.push_back(cyc + 1);
        fwq0.push_back(0);
        push_writes0();
        push_writes0();
        dq0.push_back('{err: 1'b0, cnt: 8'd0, len: 16'd66});
        dq0.push_back('{err: 1'b0, cnt: 8'd0, len: 16'd66});
        wait_cnt("u0_hold1_timeout", 0, base + 1, 200);
        repeat (5) @(negedge clk);
        if0.start = 1'b0;
        wait_cnt("u0_hold2_timeout", 0, base + 2, 200);
        repeat (3) @(negedge clk);

        // Reset during READ at addr 10, after the corrupted addr 7 was compared
        fault_en = 1'b1;
        base = done_n0;
        start_pulse0();
        i = 0;
        while (!(if0.busy && !if0.wr_en && if0.rd_addr == 5'd10) && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("u0_reached_rd10", if0.rd_addr, 10);
        chk("u0_err_before_reset", if0.err, 1);
        rst_n = 1'b0;
        #1;
        chk("u0_async_reset_outputs", {if0.wr_en, if0.wr_addr, if0.wr_data, if0.rd_addr,
                                       if0.busy, if0.done, if0.err, if0.err_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fault_en = 1'b0;
        repeat (80) @(negedge clk);
        chk("u0_no_done_after_abort", done_n0, base);
        chk("u0_idle_after_abort", if0.busy, 0);
        dq0.push_back('{err: 1'b0, cnt: 8'd0, len: 16'd66});
        start_pulse0();
        wait_cnt("u0_post_reset_timeout", 0, base + 1, 200);
        repeat (3) @(negedge clk);

        chk("queues_drained", wq0.size() + fwq0.size() + dq0.size() + dq1.size() + dq2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
